// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into big-endian 32-bit schedule
// words and appends 0x80, zero fill and the 64-bit bit-length.
module sha256_msg_padder #(
    parameter int LEN_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_blk_last,
    output logic        out_msg_last,
    output logic        busy,
    output logic        len_err
);

    // Handshake: a byte moves when in_valid && in_ready; a word moves when
    // out_valid && out_ready. out_* hold steady while out_valid && !out_ready.
    typedef enum logic [2:0] {
        S_ACCEPT,
        S_PAD1,
        S_PADZ,
        S_LEN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [5:0]       pos_q;
    logic [LEN_W-1:0] msg_bytes_q;
    logic [23:0]      asm_q;

    logic       can_take;
    logic       take;
    logic [7:0] byte_val;
    logic [5:0] pos_next;
    logic [63:0] len_bits;
    logic [63:0] len_shift;

    assign can_take  = !out_valid || out_ready;
    assign in_ready  = (state_q == S_ACCEPT) && can_take;
    assign pos_next  = pos_q + 6'd1;
    assign len_bits  = 64'(msg_bytes_q) << 3;
    // Length bytes occupy positions 56..63, MSB first.
    assign len_shift = len_bits << {pos_q[2:0], 3'b000};

    always_comb begin
        take     = 1'b0;
        byte_val = 8'h00;
        case (state_q)
            S_ACCEPT: begin
                take     = in_valid && can_take;
                byte_val = in_data;
            end
            S_PAD1: begin
                take     = can_take;
                byte_val = 8'h80;
            end
            S_PADZ: take = can_take;
            S_LEN: begin
                take     = can_take;
                byte_val = len_shift[63:56];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_ACCEPT;
            pos_q        <= '0;
            msg_bytes_q  <= '0;
            asm_q        <= '0;
            out_word     <= '0;
            out_valid    <= 1'b0;
            out_idx      <= '0;
            out_blk_last <= 1'b0;
            out_msg_last <= 1'b0;
            busy         <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (take) begin
                pos_q <= pos_next;
                if (pos_q[1:0] == 2'd3) begin
                    out_word     <= {asm_q, byte_val};
                    out_valid    <= 1'b1;
                    out_idx      <= pos_q[5:2];
                    out_blk_last <= &pos_q[5:2];
                    out_msg_last <= (state_q == S_LEN) && (&pos_q);
                end else begin
                    asm_q <= {asm_q[15:0], byte_val};
                end
            end

            case (state_q)
                S_ACCEPT: if (take) begin
                    msg_bytes_q <= msg_bytes_q + LEN_W'(1);
                    busy        <= 1'b1;
                    if (!busy) len_err <= 1'b0;
                    if (&msg_bytes_q) len_err <= 1'b1;
                    if (in_last) state_q <= S_PAD1;
                end
                S_PAD1: if (take) state_q <= (pos_next == 6'd56) ? S_LEN : S_PADZ;
                // Zero fill may wrap past 63 into an extra block before reaching 56.
                S_PADZ: if (take && pos_next == 6'd56) state_q <= S_LEN;
                S_LEN:  if (take && (&pos_q)) state_q <= S_DONE;
                S_DONE: if (out_valid && out_ready) begin
                    state_q     <= S_ACCEPT;
                    busy        <= 1'b0;
                    msg_bytes_q <= '0;
                    pos_q       <= '0;
                end
                default: state_q <= S_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: byte-queue padding model, known-answer table,
// reset and length-wrap sequences.
module tb_sha256_msg_padder;

    typedef struct {
        int          scen;
        int          widx;
        logic        ml;
        logic [31:0] w;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_blk_last, out_msg_last, busy, len_err;
    logic [31:0] out_word;
    logic [3:0]  out_idx;
    logic        in_ready2, out_valid2, out_blk_last2, out_msg_last2, busy2, len_err2;
    logic [31:0] out_word2;
    logic [3:0]  out_idx2;

    int checks = 0;
    int failures = 0;
    int rmode = 0;
    logic mon_en = 1'b0;

    logic [7:0]  msg_q[$];
    logic [37:0] exp_q[$];
    logic [31:0] got_w[$];
    logic        got_ml[$];
    logic [31:0] scen_w [7][32];
    logic        scen_ml[7][32];
    int          scen_n [7];
    logic [31:0] last2_word;
    vec_t        vecs[21];

    logic        stall_prev = 1'b0;
    logic [31:0] prev_word;
    logic [3:0]  prev_idx;
    logic        busy_chk = 1'b0;

    sha256_msg_padder #(.LEN_W(32)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_word(out_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_blk_last(out_blk_last), .out_msg_last(out_msg_last),
        .busy(busy), .len_err(len_err)
    );

    sha256_msg_padder #(.LEN_W(4)) dut_small (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready2), .out_word(out_word2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_idx(out_idx2),
        .out_blk_last(out_blk_last2), .out_msg_last(out_msg_last2),
        .busy(busy2), .len_err(len_err2)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!reset && mon_en) begin
            if (busy_chk) chk("busy_after_last", busy, 0);
            if (stall_prev) chk("stall_stable", {out_valid, out_idx, out_word}, {1'b1, prev_idx, prev_word});
            if (out_valid && !out_ready) chk("in_ready_stalled", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", {out_idx, out_word}, 0);
                    checks--;
                    if ({out_idx, out_word} === 36'd0) begin
                        failures++;
                        $display("FAIL extra_word actual=present required=none");
                    end
                    checks++;
                end else begin
                    chk("word", {out_msg_last, out_blk_last, out_idx, out_word}, exp_q.pop_front());
                end
                got_w.push_back(out_word);
                got_ml.push_back(out_msg_last);
            end
        end
        if (out_valid2 && out_ready && out_msg_last2) last2_word = out_word2;
        busy_chk   = !reset && mon_en && out_valid && out_ready && out_msg_last;
        stall_prev = !reset && out_valid && !out_ready;
        prev_word  = out_word;
        prev_idx   = out_idx;
    end

    // padding reference: byte queue -> words
    task automatic build_exp();
        logic [7:0]  p[$];
        logic [63:0] bits;
        int nw;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg_q.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
        nw = p.size() / 4;
        exp_q.delete();
        for (int i = 0; i < nw; i++)
            exp_q.push_back({i == nw - 1, (i % 16) == 15, 4'(i % 16),
                             p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]});
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap_pct);
        int acc, n;
        while ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc = 0;
        n = 0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = int'(in_ready);
            @(posedge clk); #1;
            n++;
        end
        chk("byte_accept", acc, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_msg(input int ready_mode, input int gap_pct, input int scen);
        int total, n;
        build_exp();
        total = exp_q.size();
        got_w.delete();
        got_ml.delete();
        rmode = ready_mode;
        for (int i = 0; i < msg_q.size(); i++)
            send_byte(msg_q[i], i == msg_q.size() - 1, gap_pct);
        n = 0;
        while ((got_w.size() < total || busy) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("msg_done", n < 3000, 1);
        repeat (2) @(posedge clk);
        chk("word_count", got_w.size(), total);
        chk("exp_drained", exp_q.size(), 0);
        if (scen >= 0) begin
            scen_n[scen] = got_w.size();
            for (int i = 0; i < 32 && i < got_w.size(); i++) begin
                scen_w[scen][i]  = got_w[i];
                scen_ml[scen][i] = got_ml[i];
            end
        end
        #1;
    endtask

    task automatic set_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    task automatic set_fill(input int n, input logic [7:0] b);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(b);
    endtask

    initial begin
        vecs = '{
            '{0, 0, 1'b0, 32'h61626380}, '{0, 7, 1'b0, 32'h0}, '{0, 15, 1'b1, 32'h18},
            '{1, 0, 1'b0, 32'h41414141}, '{1, 13, 1'b0, 32'h41414180},
            '{1, 14, 1'b0, 32'h0}, '{1, 15, 1'b1, 32'h1B8},
            '{2, 13, 1'b0, 32'h42424242}, '{2, 14, 1'b0, 32'h80000000},
            '{2, 15, 1'b0, 32'h0}, '{2, 16, 1'b0, 32'h0}, '{2, 31, 1'b1, 32'h1C0},
            '{3, 15, 1'b0, 32'h43434343}, '{3, 16, 1'b0, 32'h80000000},
            '{3, 17, 1'b0, 32'h0}, '{3, 31, 1'b1, 32'h200},
            '{4, 0, 1'b0, 32'h61626380}, '{4, 15, 1'b1, 32'h18},
            '{5, 0, 1'b0, 32'h61626380}, '{5, 15, 1'b1, 32'h18},
            '{6, 3, 1'b0, 32'h11111111}
        };
        for (int s = 0; s < 7; s++) begin
            scen_n[s] = 0;
            for (int i = 0; i < 32; i++) begin
                scen_w[s][i]  = 32'hDEADBEEF;
                scen_ml[s][i] = 1'bx;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {out_valid, out_word, out_idx, out_blk_last, out_msg_last, busy, len_err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        set_abc();         run_msg(0, 0, 0);
        set_fill(55, 8'h41); run_msg(0, 0, 1);
        set_fill(56, 8'h42); run_msg(0, 0, 2);
        set_fill(64, 8'h43); run_msg(0, 0, 3);

        // 16 bytes wraps the 4-bit counter of the small instance
        last2_word = 32'hFFFFFFFF;
        set_fill(16, 8'h11); run_msg(2, 10, 6);
        chk("len_err_small", len_err2, 1);
        chk("len_err_main", len_err, 0);
        chk("len_field_wrapped", last2_word, 0);

        set_abc(); run_msg(1, 30, 4);
        chk("len_err_cleared", len_err2, 0);

        for (int r = 0; r < 8; r++) begin
            msg_q.delete();
            for (int i = $urandom_range(1, 140); i > 0; i--) msg_q.push_back(8'($urandom));
            run_msg($urandom_range(0, 2), $urandom_range(0, 40), -1);
        end

        // reset in the middle of a message
        mon_en = 1'b0;
        rmode  = 0;
        for (int i = 0; i < 20; i++) send_byte(8'h5A, 1'b0, 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset_outputs", {out_valid, out_word, out_idx, out_blk_last, out_msg_last, busy, len_err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        got_w.delete();
        @(negedge clk);
        chk("in_ready_after_mid_reset", in_ready, 1);
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_words_after_reset", got_w.size(), 0);
        set_abc(); run_msg(0, 0, 5);

        for (int i = 0; i < 21; i++) begin
            chk($sformatf("vec%0d_s%0d_w%0d", i, vecs[i].scen, vecs[i].widx),
                {scen_ml[vecs[i].scen][vecs[i].widx], scen_w[vecs[i].scen][vecs[i].widx]},
                {vecs[i].ml, vecs[i].w});
        end
        chk("count_abc", scen_n[0], 16);
        chk("count_55", scen_n[1], 16);
        chk("count_56", scen_n[2], 32);
        chk("count_64", scen_n[3], 32);
        chk("count_abc_stall", scen_n[4], 16);
        chk("count_abc_reset", scen_n[5], 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
